vt512_result_tx: RTL and testbench
==================================

VT512_RESULT_TX -- requirements
Module: vt512_result_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the GPIO word and payload width; only 32 is supported.
REQ-002 The block SHALL have parameter MAX_WORDS, default 512, giving the maximum payload words per packet.
REQ-003 Port clk, input, 1 bit: clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start_i, input, 1 bit: single-cycle packet request.
REQ-006 Port dest_addr_i, input, 28 bits: destination address, placed in header bits [31:4].
REQ-007 Port type_i, input, 4 bits: packet type (CONFIG/WEIGHTS/BIASES/IMAGE code), placed in header bits [3:0].
REQ-008 Port len_i, input, 10 bits: payload word count.
REQ-009 Port in_valid_i, input, 1 bit: payload word available.
REQ-010 Port in_data_i, input, DATA_WIDTH bits: payload word.
REQ-011 Port in_ready_o, output, 1 bit: payload word consumed on a clk edge where in_valid_i and in_ready_o are both 1.
REQ-012 Port gpio_data_o, output, 32 bits: word driven to the GPIO receiver.
REQ-013 Port gpio_valid_o, output, 1 bit: gpio_data_o holds a valid word.
REQ-014 Port gpio_last_o, output, 1 bit: current word is the final word of the packet.
REQ-015 Port gpio_ack_i, input, 1 bit: receiver accepts the word; a transfer SHALL occur on an edge where gpio_valid_o and gpio_ack_i are both 1.
REQ-016 Port busy_o, output, 1 bit: packet in progress.
REQ-017 Port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, HEADER, PAYLOAD and TRAILER; TRAILER exists only per REQ-033.
REQ-019 In IDLE, start_i=1 SHALL latch dest_addr_i, type_i and len_i; the FSM SHALL enter HEADER with gpio_valid_o=1 and gpio_data_o={dest_addr,type} on the next cycle.
REQ-020 start_i SHALL be ignored when the FSM is not in IDLE.
REQ-021 len_i above MAX_WORDS SHALL saturate to MAX_WORDS.
REQ-022 len_i=0 SHALL produce a header-only packet with gpio_last_o=1 on the header.
REQ-023 While gpio_valid_o=1 and gpio_ack_i=0, gpio_data_o and gpio_last_o SHALL remain stable.
REQ-024 in_ready_o SHALL equal (state is HEADER or PAYLOAD) AND (words remaining > 0) AND (gpio_valid_o=0 OR gpio_ack_i=1), so that no output-register bubble is required.
REQ-025 A consumed payload word SHALL appear on gpio_data_o on the next cycle with gpio_valid_o=1, and the remaining-word count SHALL decrement.
REQ-026 With gpio_ack_i and in_valid_i held high, the block SHALL sustain one transfer per cycle.
REQ-027 If the output word is transferred and no new payload word is consumed in the same cycle, gpio_valid_o SHALL drop to 0 on the next cycle.
REQ-028 gpio_last_o SHALL be 1 only on the final word: payload word len, the header when len=0, or the trailer when REQ-033 applies.
REQ-029 After the transfer of the final word, the FSM SHALL return to IDLE, drive done_o=1 for exactly one cycle and drive gpio_valid_o=0; start_i SHALL be accepted during that done_o cycle.
REQ-030 busy_o SHALL be 1 in every state other than IDLE.
REQ-031 in_valid_i asserted while in_ready_o=0 SHALL NOT consume data.

Reset
REQ-032 On reset, including mid-packet, the block SHALL enter IDLE and hold in_ready_o, gpio_valid_o, gpio_last_o, busy_o and done_o at 0, gpio_data_o at 0 and all counters at 0; any partial packet SHALL be abandoned.

Configuration
REQ-033 With VT512_TX_CHECKSUM_EN defined, the block SHALL keep a 32-bit XOR accumulator of all payload words, cleared on start, and send it in TRAILER after the last payload word (header when len=0); the trailer SHALL carry gpio_last_o=1 and payload words SHALL carry gpio_last_o=0.
REQ-034 Without VT512_TX_CHECKSUM_EN, the block SHALL have no TRAILER state and no accumulator, and the final payload word SHALL carry gpio_last_o=1.

Verification
REQ-035 start, addr=0x0000123, type=4, len=3, payload A1/B2/C3, ack always 1 -> words 0x00001234, A1, B2, C3 on consecutive cycles; last on C3; done_o one cycle later.
REQ-036 len=2, ack held 0 for 5 cycles on the header -> header stable for 5 cycles, in_ready_o=0, no payload consumed.
REQ-037 len=0, type=1 -> single header word with last=1, then done_o; with the macro defined -> header, then trailer 0x00000000 with last=1.
REQ-038 Macro defined, payload 0xF0F0F0F0 and 0x0FF00FF0 -> trailer 0xFF00FF00 with last=1.
REQ-039 len=1023 -> exactly 512 payload words sent; reset asserted after word 100 -> all outputs 0 next cycle, and a new start is accepted afterwards.

Source files
------------

// File: rtl/vt512_result_tx.sv
// vt512_result_tx: packetises a stream of result words for the GPIO receiver.
// Each packet is a header word {dest_addr, type}, followed by up to MAX_WORDS
// payload words. gpio_last_o marks the final word of the packet.
//
// Optional feature, selected by the macro VT512_TX_CHECKSUM_EN:
//   when defined, a trailer word carrying the XOR of all payload words is
//   appended, and only the trailer carries gpio_last_o.
//
// Handshakes (both sides use strict valid/ready semantics):
//   input side : a word moves on a rising edge where in_valid_i && in_ready_o.
//   output side: a word moves on a rising edge where gpio_valid_o && gpio_ack_i;
//                while gpio_valid_o=1 and gpio_ack_i=0, data and last hold.
// state_o exposes the FSM state for debug and checker binding.
module vt512_result_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [27:0]           dest_addr_i,
    input  logic [3:0]            type_i,
    input  logic [9:0]            len_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic [31:0]           gpio_data_o,
    output logic                  gpio_valid_o,
    output logic                  gpio_last_o,
    input  logic                  gpio_ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            state_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
`ifdef VT512_TX_CHECKSUM_EN
    localparam logic [1:0] S_TRAILER = 2'd3;
`endif

    localparam logic [9:0] MAX_LEN = 10'(MAX_WORDS);

    logic [1:0]  state_q;
    logic [9:0]  remaining_q;   // payload words still to be consumed
    logic [31:0] data_q;
    logic        valid_q;
    logic        last_q;
    logic        done_q;
`ifdef VT512_TX_CHECKSUM_EN
    logic [31:0] acc_q;
`endif

    logic [9:0]  len_sat;
    logic        out_free;
    logic        take;
    logic        xfer;

    // Oversized requests are clipped to the packet limit.
    assign len_sat = (len_i > MAX_LEN) ? MAX_LEN : len_i;

    // The output register can be refilled in the same cycle it is emptied,
    // so a steady stream needs no bubble between words.
    assign out_free   = !valid_q || gpio_ack_i;
    assign in_ready_o = ((state_q == S_HEADER) || (state_q == S_PAYLOAD)) &&
                        (remaining_q != 10'd0) && out_free;
    assign take       = in_ready_o && in_valid_i;
    assign xfer       = valid_q && gpio_ack_i;

    assign gpio_data_o  = data_q;
    assign gpio_valid_o = valid_q;
    assign gpio_last_o  = last_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign state_o      = state_q;

    // Packet sequencing: header load, payload forwarding, optional trailer, done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 10'd0;
            data_q      <= 32'd0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef VT512_TX_CHECKSUM_EN
            acc_q       <= 32'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_HEADER;
                        remaining_q <= len_sat;
                        data_q      <= {dest_addr_i, type_i};
                        valid_q     <= 1'b1;
`ifdef VT512_TX_CHECKSUM_EN
                        // The trailer always follows, so the header is never last.
                        last_q      <= 1'b0;
                        acc_q       <= 32'd0;
`else
                        last_q      <= (len_sat == 10'd0);
`endif
                    end
                end

                S_HEADER, S_PAYLOAD: begin
                    if (take) begin
                        // Refill the output register with the next payload word.
                        state_q     <= S_PAYLOAD;
                        data_q      <= in_data_i;
                        valid_q     <= 1'b1;
                        remaining_q <= remaining_q - 10'd1;
`ifdef VT512_TX_CHECKSUM_EN
                        last_q      <= 1'b0;
                        acc_q       <= acc_q ^ in_data_i;
`else
                        last_q      <= (remaining_q == 10'd1);
`endif
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (remaining_q == 10'd0) begin
`ifdef VT512_TX_CHECKSUM_EN
                            state_q <= S_TRAILER;
                            data_q  <= acc_q;
                            valid_q <= 1'b1;
                            last_q  <= 1'b1;
`else
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end

`ifdef VT512_TX_CHECKSUM_EN
                S_TRAILER: begin
                    if (xfer) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vt512_result_tx.sv
// Bench for vt512_result_tx. A packet-level reference model builds the full
// expected word sequence (header, payload, optional XOR trailer) into a queue;
// the monitor pops it as words are accepted by the receiver. Honours
// VT512_TX_CHECKSUM_EN the same way as the design.
module tb_vt512_result_tx;

    localparam int MW = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [27:0] dest_addr_i;
    logic [3:0]  type_i;
    logic [9:0]  len_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic [31:0] gpio_data_o;
    logic        gpio_valid_o;
    logic        gpio_last_o;
    logic        gpio_ack_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];   // words the receiver must still see, in order
    logic [31:0] src_q[$];   // payload words still to be offered to the DUT
    logic [31:0] fixed_q[$]; // optional directed payload for the next packet

    // Clock block
    always #5 clk = ~clk;

    vt512_result_tx dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .dest_addr_i  (dest_addr_i),
        .type_i       (type_i),
        .len_i        (len_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .gpio_data_o  (gpio_data_o),
        .gpio_valid_o (gpio_valid_o),
        .gpio_last_o  (gpio_last_o),
        .gpio_ack_i   (gpio_ack_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .state_o      (state_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd0);
        check_val({tag, "_valid"},    {31'd0, gpio_valid_o}, 32'd0);
        check_val({tag, "_last"},     {31'd0, gpio_last_o}, 32'd0);
        check_val({tag, "_busy"},     {31'd0, busy_o}, 32'd0);
        check_val({tag, "_done"},     {31'd0, done_o}, 32'd0);
        check_val({tag, "_data"},     gpio_data_o, 32'd0);
    endtask

    // Driver + monitor for one packet. Called with the clock away from its
    // rising edge; returns at the falling edge of the done cycle (or after an
    // abort) so a following call can start inside the done cycle.
    task automatic run_pkt(input logic [27:0] addr, input logic [3:0] typ, input int len,
                           input int ack_pct, input int vld_pct, input int hold_ack,
                           input int abort_at, input bit tight);
        int          n;
        int          total;
        int          cycles;
        int          xfers;
        int          bubbles;
        bit          done_seen;
        bit          aborted;
        logic [31:0] w;
        logic [31:0] acc;

        // Reference model: the whole packet as the receiver should see it.
        n = (len > MW) ? MW : len;
        acc = 32'd0;
        exp_q.delete();
        src_q.delete();
        exp_q.push_back({addr, typ});
        for (int i = 0; i < n; i++) begin
            w = (fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
            src_q.push_back(w);
            exp_q.push_back(w);
            acc = acc ^ w;
        end
        fixed_q.delete();
`ifdef VT512_TX_CHECKSUM_EN
        exp_q.push_back(acc);
`endif
        total = exp_q.size();

        check_val("idle_busy", {31'd0, busy_o}, 32'd0);
        start_i     = 1'b1;
        dest_addr_i = addr;
        type_i      = typ;
        len_i       = len[9:0];
        in_valid_i  = 1'b0;
        gpio_ack_i  = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b0;

        cycles = 0; xfers = 0; bubbles = 0; done_seen = 0; aborted = 0;
        while (!done_seen && cycles < 5000) begin
            // Drive this cycle. Stray starts are only issued while words remain,
            // so they never fall into the done cycle where they would be legal.
            gpio_ack_i = (cycles < hold_ack) ? 1'b0 : ($urandom_range(0, 99) < ack_pct);
            in_valid_i = ($urandom_range(0, 99) < vld_pct);
            in_data_i  = (src_q.size() > 0) ? src_q[0] : $urandom;
            start_i    = (exp_q.size() > 0) && ($urandom_range(0, 9) == 0);
            dest_addr_i = 28'($urandom);
            type_i      = 4'($urandom);
            len_i       = 10'($urandom);

            @(negedge clk);
            if (done_o) begin
                done_seen = 1;
                check_val("done_words_left", exp_q.size(), 32'd0);
                check_val("done_src_left", src_q.size(), 32'd0);
                check_val("done_valid", {31'd0, gpio_valid_o}, 32'd0);
                check_val("done_busy", {31'd0, busy_o}, 32'd0);
                if (tight) check_val("tight_cycles", cycles, total);
                if (tight) check_val("tight_bubbles", bubbles, 32'd0);
            end else begin
                check_val("busy", {31'd0, busy_o}, 32'd1);
                if (cycles < hold_ack) check_val("hold_in_ready", {31'd0, in_ready_o}, 32'd0);
                if (in_valid_i && in_ready_o) begin
                    if (src_q.size() == 0) check_val("extra_consume", 32'd1, 32'd0);
                    else void'(src_q.pop_front());
                end
                if (gpio_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_word", gpio_data_o, 32'hFFFF_FFFF ^ gpio_data_o);
                    end else begin
                        check_val("data", gpio_data_o, exp_q[0]);
                        check_val("last", {31'd0, gpio_last_o}, {31'd0, exp_q.size() == 1});
                        if (gpio_ack_i) begin
                            void'(exp_q.pop_front());
                            xfers++;
                        end
                    end
                end else begin
                    bubbles++;
                    check_val("idle_last", {31'd0, gpio_last_o}, 32'd0);
                end
                if (abort_at >= 0 && xfers == abort_at) begin
                    reset      = 1'b1;
                    start_i    = 1'b0;
                    in_valid_i = 1'b0;
                    #1;
                    check_outputs_zero("abort");
                    @(posedge clk);
                    #1;
                    reset   = 1'b0;
                    aborted = 1;
                    break;
                end
            end
            if (!done_seen) begin
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        if (!aborted) check_val("pkt_done", {31'd0, done_seen}, 32'd1);
        start_i    = 1'b0;
        in_valid_i = 1'b0;
    endtask

    initial begin
        int len;
        reset       = 1'b1;
        start_i     = 1'b0;
        dest_addr_i = 28'd0;
        type_i      = 4'd0;
        len_i       = 10'd0;
        in_valid_i  = 1'b0;
        in_data_i   = 32'd0;
        gpio_ack_i  = 1'b0;

        // Reset block
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed: three words streamed with ack always high.
        fixed_q = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3};
        run_pkt(28'h0000123, 4'h4, 3, 100, 100, 0, -1, 1);
        @(posedge clk);
        #1;

        // Directed: receiver stalls the header for five cycles.
        run_pkt(28'($urandom), 4'h2, 2, 100, 100, 5, -1, 0);

        // Directed: header-only packet, started inside the previous done cycle.
        run_pkt(28'($urandom), 4'h1, 0, 100, 100, 0, -1, 1);

        // Directed: known XOR trailer value.
        fixed_q = '{32'hF0F0_F0F0, 32'h0FF0_0FF0};
        run_pkt(28'($urandom), 4'h3, 2, 100, 100, 0, -1, 1);

        // Random packets with random handshake pressure.
        for (int p = 0; p < 24; p++) begin
            if ($urandom_range(0, 5) == 0) len = $urandom_range(513, 1023);
            else len = $urandom_range(0, 20);
            run_pkt(28'($urandom), 4'($urandom), len,
                    $urandom_range(30, 100), $urandom_range(30, 100),
                    $urandom_range(0, 3), -1, 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        // Oversized request clipped to 512 words, full throughput.
        run_pkt(28'($urandom), 4'h4, 1023, 100, 100, 0, -1, 1);

        // Reset mid-packet after payload word 100 has gone out.
        run_pkt(28'($urandom), 4'h4, 1023, 100, 100, 0, 102, 0);

        // A new packet is accepted after the abort.
        run_pkt(28'($urandom), 4'h2, 5, 70, 70, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
